// File: rtl/bus_mailbox.sv
// bus_mailbox: 6502 bus target with a 4-byte register window, wait-state
// insertion, a TX byte FIFO (CPU to outside) and an RX byte FIFO (outside
// to CPU), plus a level interrupt request.
`timescale 1ns/1ps
module bus_mailbox #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          WAIT_STATES = 1,
  parameter int          DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        req,
  output logic        rdy,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0]       WAIT_CNT = 3'(WAIT_STATES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic [7:0] txMem [DEPTH];
  logic [7:0] rxMem [DEPTH];

  logic [2:0]       waitCnt_q, waitCnt_d;
  logic [PTR_W-1:0] txWr_q, txWr_d, txRd_q, txRd_d;
  logic [PTR_W-1:0] rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic [CNT_W-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             rxUnderflow_q, rxUnderflow_d;
  logic             txOverflow_q, txOverflow_d;

  logic       sel, commit;
  logic [1:0] offset;
  logic       txFull, rxEmpty, rxFull;
  logic       txPushReq, txPush, txPop;
  logic       rxPopReq, rxPop, rxPush;
  logic [7:0] status;

  // Address decode, stall handshake and FIFO push/pop qualification
  always_comb begin
    sel       = req && (addr[15:2] == BASE_ADDR[15:2]);
    offset    = addr[1:0];
    rdy       = ~(sel && (waitCnt_q != WAIT_CNT));
    commit    = sel && rdy;
    rdata_oe  = sel && rw && rdy;
    txFull    = (txCount_q == FULL_CNT);
    rxFull    = (rxCount_q == FULL_CNT);
    rxEmpty   = (rxCount_q == '0);
    tx_valid  = (txCount_q != '0);
    tx_data   = txMem[txRd_q];
    rx_ready  = ~rxFull;
    irq       = (ctrl_q[0] && !rxEmpty) || (ctrl_q[1] && !tx_valid);
    txPop     = tx_valid && tx_ready;
    txPushReq = commit && !rw && (offset == 2'd0);
    txPush    = txPushReq && (!txFull || txPop);
    rxPopReq  = commit && rw && (offset == 2'd0);
    rxPop     = rxPopReq && !rxEmpty;
    rxPush    = rx_valid && rx_ready;
    status    = {irq, 3'b000, txOverflow_q, rxUnderflow_q, txFull, !rxEmpty};
  end

  // Read mux: data appears only in the committing cycle of a read
  always_comb begin
    rdata = 8'h00;
    if (commit && rw) begin
      case (offset)
        2'd0:    rdata = rxEmpty ? 8'h00 : rxMem[rxRd_q];
        2'd1:    rdata = status;
        2'd2:    rdata = {6'b000000, ctrl_q};
        default: rdata = 8'h00;
      endcase
    end
  end

  // Next-state for wait counter, pointers, counts, control and sticky flags
  always_comb begin
    waitCnt_d     = waitCnt_q;
    txWr_d        = txWr_q;
    txRd_d        = txRd_q;
    rxWr_d        = rxWr_q;
    rxRd_d        = rxRd_q;
    txCount_d     = txCount_q;
    rxCount_d     = rxCount_q;
    ctrl_d        = ctrl_q;
    rxUnderflow_d = rxUnderflow_q;
    txOverflow_d  = txOverflow_q;

    if (!sel)       waitCnt_d = 3'd0;
    else if (!rdy)  waitCnt_d = waitCnt_q + 3'd1;
    else            waitCnt_d = 3'd0;

    if (txPush) txWr_d = txWr_q + ONE_PTR;
    if (txPop)  txRd_d = txRd_q + ONE_PTR;
    if (txPush && !txPop)      txCount_d = txCount_q + ONE_CNT;
    else if (!txPush && txPop) txCount_d = txCount_q - ONE_CNT;

    if (rxPush) rxWr_d = rxWr_q + ONE_PTR;
    if (rxPop)  rxRd_d = rxRd_q + ONE_PTR;
    if (rxPush && !rxPop)      rxCount_d = rxCount_q + ONE_CNT;
    else if (!rxPush && rxPop) rxCount_d = rxCount_q - ONE_CNT;

    // Clear first so that a same-edge set takes priority
    if (commit && !rw && (offset == 2'd1)) begin
      if (wdata[2]) rxUnderflow_d = 1'b0;
      if (wdata[3]) txOverflow_d  = 1'b0;
    end
    if (rxPopReq && rxEmpty)           rxUnderflow_d = 1'b1;
    if (txPushReq && txFull && !txPop) txOverflow_d  = 1'b1;

    if (commit && !rw && (offset == 2'd2)) ctrl_d = wdata[1:0];
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt_q     <= 3'd0;
      txWr_q        <= '0;
      txRd_q        <= '0;
      rxWr_q        <= '0;
      rxRd_q        <= '0;
      txCount_q     <= '0;
      rxCount_q     <= '0;
      ctrl_q        <= 2'b00;
      rxUnderflow_q <= 1'b0;
      txOverflow_q  <= 1'b0;
    end else begin
      waitCnt_q     <= waitCnt_d;
      txWr_q        <= txWr_d;
      txRd_q        <= txRd_d;
      rxWr_q        <= rxWr_d;
      rxRd_q        <= rxRd_d;
      txCount_q     <= txCount_d;
      rxCount_q     <= rxCount_d;
      ctrl_q        <= ctrl_d;
      rxUnderflow_q <= rxUnderflow_d;
      txOverflow_q  <= txOverflow_d;
    end
  end

  // FIFO storage; contents are meaningless until counted valid, so no reset
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr_q] <= wdata;
    if (rxPush) rxMem[rxWr_q] <= rx_data;
  end

endmodule

// File: doc/bus_mailbox.md
Name: bus_mailbox

Overview:
- Memory-mapped bus target for the 6502 core's external bus. It answers CPU read and write cycles in a 4-byte window.
- Drives RDY low to insert wait states.
- Bridges the CPU to an external byte stream through a TX FIFO (CPU to outside) and an RX FIFO (outside to CPU).
- Raises an interrupt request to the core.

Parameters:
BASE_ADDR, 16'hD000, window base; bits [1:0] ignored
WAIT_STATES, 1, stall cycles per selected access (0..7)
DEPTH, 4, entries per FIFO (power of 2, 2..16)

Ports:
clk  input  1  system clock; all state on posedge
reset  input  1  asynchronous, active-low reset
addr  input  16  CPU address
wdata  input  8  CPU write data
rw  input  1  1=read, 0=write
req  input  1  CPU bus cycle valid
rdy  output  1  to CPU RDY; low stalls the cycle
rdata  output  8  read data to CPU
rdata_oe  output  1  enable for core's 8-bit tristate onto data bus
tx_data  output  8  head of TX FIFO
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  consumer pops TX head when tx_valid&tx_ready at posedge
rx_data  input  8  producer byte
rx_valid  input  1  producer offers byte
rx_ready  output  1  RX FIFO not full; push on rx_valid&rx_ready at posedge
irq  output  1  interrupt request, active-high

Behaviour:
Decode and registers:
- sel = req & (addr[15:2]==BASE_ADDR[15:2]).
- Offset 0 DATA: write pushes TX; read returns RX head and pops.
- Offset 1 STATUS (read): bit0 rx_nonempty, bit1 tx_full, bit2 rx_underflow (sticky), bit3 tx_overflow (sticky), bit7 irq, others 0.
- Offset 1 write: write-1-to-clear for bits 2,3.
- Offset 2 CTRL (R/W): bit0 rx_irq_en, bit1 tx_empty_irq_en, others read 0.
- Offset 3: reads 8'h00; writes ignored.

Wait-state counter:
- 3-bit stall counter cnt. rdy = ~(sel & (cnt != WAIT_STATES)), combinational.
- On a posedge with sel & ~rdy: cnt increments.
- On a posedge with sel & rdy: the access commits exactly once and cnt returns to 0.
- Each selected access therefore takes WAIT_STATES+1 cycles. With WAIT_STATES=0, rdy stays 1 and every selected cycle commits.
- The CPU holds addr, rw and wdata stable while rdy is low.
- If req drops or addr leaves the window mid-stall, cnt clears to 0 on the next posedge and nothing commits.
- Unselected cycles: rdy=1, rdata=8'h00, rdata_oe=0.

Read data:
- rdata_oe = sel & rw & rdy. rdata is valid in the commit cycle only; otherwise 8'h00.
- Side effects (pop, W1C, push, CTRL write) occur on the commit posedge.

FIFO rules:
- Circular buffers with wrapping pointers and a count of 0..DEPTH.
- tx_full = (count==DEPTH). rx_ready = ~rx_full.
- CPU write to DATA with TX full and no simultaneous tx pop: byte dropped, tx_overflow set.
- CPU write to DATA with TX full and a tx pop on the same edge: push accepted, count unchanged, no overflow.
- CPU read of DATA with RX empty: returns 8'h00, no pop, rx_underflow set. A simultaneous rx push still lands.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged.
- Sticky set and W1C clear on the same edge: set wins.

Interrupt:
- irq = (rx_irq_en & rx_nonempty) | (tx_empty_irq_en & ~tx_valid), combinational from flops.

Reset (reset=0):
- Clears immediately, mid-access included: FIFOs empty, pointers 0, cnt=0, CTRL=0, sticky bits 0.
- Outputs during and after reset: tx_valid=0, rx_ready=1, irq=0, rdata=8'h00, rdata_oe=0.
- rdy follows its equation: 1 unless sel.
- A stalled access interrupted by reset restarts its full wait count once reset releases.

Test Plan:
- Reset then idle, WAIT_STATES=1 -> tx_valid=0, rx_ready=1, irq=0, rdy=1; read STATUS returns 8'h00 with rdy low for 1 cycle then rdata_oe=1.
- Write 8'hA5 to 16'hD000 with tx_ready=0 -> rdy low 1 cycle; then tx_valid=1, tx_data=8'hA5. Raise tx_ready -> pop, tx_valid=0.
- Write 5 bytes 01..05 with tx_ready=0, DEPTH=4 -> STATUS=8'h0A (bit1 full, bit3 overflow). Drain order 01,02,03,04. Write 8'h08 to 16'hD001 -> bit3 clears.
- Push 8'h3C, 8'h7E via rx_valid with CTRL=8'h01 -> irq=1. Two DATA reads return 3C then 7E; irq=0. Third read returns 00; STATUS bit2=1.
- Fill RX to 4 -> rx_ready=0. CPU read of DATA on the same edge as rx_valid -> no push that cycle; rx_ready=1 next cycle. Next push accepted and wraps pointer to slot 0.
- Assert reset during a stalled read with WAIT_STATES=3 -> CTRL/FIFOs cleared. After release, the access stalls 3 full cycles before committing. Access to 16'hD004 -> rdy=1, rdata_oe=0.
